// File: rtl/profpga_sim_end_ctrl.sv
// rtl/profpga_sim_end_ctrl.sv - end-of-run controller: done-source collection, minimum run time, watchdog
//
// Optional build macro: SIM_END_STOP_EN
//   When defined, the RUN->DONE and RUN->TIMEOUT transitions print a message and call $stop(0).
//   This is simulation-only code; port behaviour is the same with or without the macro.
//
// Ports:
//   mmi64_clk    : single clock, all logic on the rising edge
//   mmi64_reset  : synchronous active-high reset
//   arm_i        : start or re-arm a run; a pulse or a level both work, and it is ignored while running
//   src_done_i   : per-source done levels; a rising edge marks that source as done
//   src_mask_i   : 1 = source required for done; captured when the run is armed
//   busy_o       : a run is in progress
//   done_o       : level; the run ended with all required sources done
//   done_pulse_o : single-cycle pulse on the first cycle of done_o
//   timeout_o    : level; the watchdog expired before the run completed
//   seen_o       : sticky per-source done flags for the current or last run
//   cycle_cnt_o  : RUN cycles elapsed; saturates at its maximum and freezes when the run ends

module profpga_sim_end_ctrl #(
    parameter int N_SRC          = 4,
    parameter int CNT_W          = 32,
    parameter int MIN_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             mmi64_clk,
    input  logic             mmi64_reset,
    input  logic             arm_i,
    input  logic [N_SRC-1:0] src_done_i,
    input  logic [N_SRC-1:0] src_mask_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_pulse_o,
    output logic             timeout_o,
    output logic [N_SRC-1:0] seen_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_CYCLES);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TMO_EN  = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] src_prev_q;
    logic [N_SRC-1:0] seen_q, seen_d, seen_run;
    logic [N_SRC-1:0] src_edge;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             start;
    logic             end_ok;
    logic             tmo_hit;

    always_comb begin
        // Edge detection runs in every state, so a source already high at arm
        // must fall and rise again before it counts.
        src_edge = src_done_i & ~src_prev_q;
        seen_run = seen_q | src_edge;
        // Both comparisons use the pre-increment count; done has priority over timeout.
        end_ok   = (&(seen_run | ~mask_q)) && (cnt_q >= MIN_C);
        tmo_hit  = TMO_EN && (cnt_q >= TMO_C);

        state_d  = state_q;
        seen_d   = seen_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        start    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (arm_i) begin
                    state_d = ST_RUN;
                    seen_d  = '0;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                seen_d = seen_run;
                cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (end_ok) begin
                    state_d = ST_DONE;
                    pulse_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mmi64_clk) begin
        if (mmi64_reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            src_prev_q <= '0;
            seen_q     <= '0;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_prev_q <= src_done_i;
            seen_q     <= seen_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
            if (start) begin
                mask_q <= src_mask_i;
            end
        end
    end

    assign busy_o       = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_DONE);
    assign timeout_o    = (state_q == ST_TIMEOUT);
    assign done_pulse_o = pulse_q;
    assign seen_o       = seen_q;
    assign cycle_cnt_o  = cnt_q;

`ifdef SIM_END_STOP_EN
    always @(posedge mmi64_clk) begin
        if (!mmi64_reset && state_q == ST_RUN) begin
            if (state_d == ST_DONE) begin
                $timeformat(-12, 0, " ps", 1);
                $display("%t: Reached end of simulation.", $time);
                $stop(0);
            end else if (state_d == ST_TIMEOUT) begin
                $timeformat(-12, 0, " ps", 1);
                $display("%t: Simulation TIMEOUT, seen=%h", $time, seen_d);
                $stop(0);
            end
        end
    end
`else
    // Synthesisable build: no simulation hooks.
`endif

endmodule

// File: tb/tb_profpga_sim_end_ctrl.sv
// tb/tb_profpga_sim_end_ctrl.sv - self-checking bench for profpga_sim_end_ctrl
module tb_profpga_sim_end_ctrl;

    localparam int N_SRC = 4;
    localparam int CNT_W = 32;
    localparam int MIN_C = 10;
    localparam int TMO_C = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic [N_SRC-1:0] src;
    logic [N_SRC-1:0] mask;
    logic             busy, done, pulse, tmo;
    logic [N_SRC-1:0] seen;
    logic [CNT_W-1:0] cnt;

    always #5 clk = ~clk;

    profpga_sim_end_ctrl #(
        .N_SRC(N_SRC), .CNT_W(CNT_W), .MIN_CYCLES(MIN_C), .TIMEOUT_CYCLES(TMO_C)
    ) dut (
        .mmi64_clk(clk), .mmi64_reset(rst), .arm_i(arm),
        .src_done_i(src), .src_mask_i(mask),
        .busy_o(busy), .done_o(done), .done_pulse_o(pulse), .timeout_o(tmo),
        .seen_o(seen), .cycle_cnt_o(cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a run is "open" from arm until either every required
    // source has been seen (after the minimum time) or the watchdog expires.
    bit          m_running, m_finished, m_timed_out, m_pulse;
    longint      m_cycles;
    bit [3:0]    m_seen, m_req, m_last;

    task automatic model_step();
        bit [3:0] rises;
        bit [3:0] seen_after;
        rises = src & ~m_last;
        m_pulse = 0;
        if (rst) begin
            m_running = 0; m_finished = 0; m_timed_out = 0;
            m_cycles = 0; m_seen = 0; m_req = 0; rises = 0;
            m_last = 0;
            return;
        end
        if (m_running) begin
            seen_after = m_seen | rises;
            if ((seen_after & m_req) == m_req && m_cycles >= MIN_C) begin
                m_finished = 1; m_pulse = 1; m_running = 0;
            end else if (m_cycles >= TMO_C) begin
                m_timed_out = 1; m_running = 0;
            end
            m_seen = seen_after;
            if (m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
        end else if (arm) begin
            m_running = 1; m_finished = 0; m_timed_out = 0;
            m_cycles = 0; m_seen = 0; m_req = mask;
        end
        m_last = src;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] mask;
        int         rise[4];
        logic       exp_done;
        logic       exp_tmo;
        logic [3:0] exp_seen;
        int         exp_cnt;
    } scen_t;

    function automatic scen_t mk(logic [3:0] m, int r0, int r1, int r2, int r3,
                                 logic d, logic t, logic [3:0] s, int c);
        scen_t x;
        x.mask = m;
        x.rise[0] = r0; x.rise[1] = r1; x.rise[2] = r2; x.rise[3] = r3;
        x.exp_done = d; x.exp_tmo = t; x.exp_seen = s; x.exp_cnt = c;
        return x;
    endfunction

    scen_t tbl[6];

    initial begin
        tbl[0] = mk(4'hF,  3,  5,  7, 20, 1, 0, 4'hF, 21);
        tbl[1] = mk(4'h3,  1,  2, -1, -1, 1, 0, 4'h3, 11);
        tbl[2] = mk(4'hF,  1,  2,  3, -1, 0, 1, 4'h7, 51);
        tbl[3] = mk(4'hF,  1,  2,  3, 50, 1, 0, 4'hF, 51);
        tbl[4] = mk(4'h0, -1, -1,  4, -1, 1, 0, 4'h4, 11);
        tbl[5] = mk(4'h1, 30,  5, -1, -1, 1, 0, 4'h3, 31);

        rst = 1; arm = 0; src = 0; mask = 0;

        // Reset for five cycles, then toggle sources while idle.
        repeat (5) tick();
        chk("reset_outputs", {busy, done, pulse, tmo, seen, cnt}, 40'h0);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            src = src ^ 4'($urandom_range(1, 15));
            tick();
        end
        chk("idle_seen", seen, 4'h0);
        chk("idle_busy", busy, 1'b0);

        // Source already high at arm; arm held during RUN must not restart.
        src = 4'h1; mask = 4'h1; tick();
        arm = 1; tick();
        for (int k = 0; k < 15; k++) tick();
        chk("high_at_arm_busy", busy, 1'b1);
        chk("high_at_arm_cnt", cnt, 32'd15);
        chk("high_at_arm_seen", seen, 4'h0);
        arm = 0; src = 4'h0; tick();
        src = 4'h1; tick();
        chk("rerise_done", done, 1'b1);
        chk("rerise_cnt", cnt, 32'd17);
        chk("rerise_seen", seen, 4'h1);

        // Reset at RUN cycle 8 aborts without a pulse.
        src = 0; tick();
        mask = 4'hF; arm = 1; tick();
        arm = 0;
        repeat (8) tick();
        chk("pre_abort_cnt", cnt, 32'd8);
        rst = 1; tick();
        chk("abort_outputs", {busy, done, pulse, tmo, seen, cnt}, 40'h0);
        rst = 0; tick();
        chk("abort_idle", {busy, done, pulse, tmo}, 4'h0);

        // Table-driven runs, each re-armed from the previous end state.
        for (int i = 0; i < 6; i++) begin
            int k;
            src = 0; tick();
            mask = tbl[i].mask; arm = 1; tick();
            arm = 0; mask = 4'($urandom);
            chk($sformatf("s%0d_arm", i), {busy, done, tmo, seen, cnt}, {3'b100, 4'h0, 32'd0});
            k = 0;
            while (busy && k < 200) begin
                for (int b = 0; b < 4; b++)
                    src[b] = (tbl[i].rise[b] >= 0) && (k >= tbl[i].rise[b]);
                tick();
                k++;
            end
            chk($sformatf("s%0d_busy", i), busy, 1'b0);
            chk($sformatf("s%0d_done", i), done, tbl[i].exp_done);
            chk($sformatf("s%0d_pulse", i), pulse, tbl[i].exp_done);
            chk($sformatf("s%0d_tmo", i), tmo, tbl[i].exp_tmo);
            chk($sformatf("s%0d_seen", i), seen, tbl[i].exp_seen);
            chk($sformatf("s%0d_cnt", i), cnt, 64'(tbl[i].exp_cnt));
            tick();
            chk($sformatf("s%0d_pulse_end", i), pulse, 1'b0);
            chk($sformatf("s%0d_hold", i), {done, tmo, seen, cnt},
                {tbl[i].exp_done, tbl[i].exp_tmo, tbl[i].exp_seen, 32'(tbl[i].exp_cnt)});
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            arm  = ($urandom_range(0, 15) == 0);
            mask = 4'($urandom);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) src[b] = ~src[b];
            tick();
            chk("random", {busy, done, pulse, tmo, seen, cnt},
                {m_running, m_finished, m_pulse, m_timed_out, m_seen, m_cycles[31:0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
